// File: rtl/dmem_request_ctrl.sv
// Memory-stage data-cache initiator: issues the EX/MEM load/store, holds it until dhit_in,
// captures read data and blocks re-issue of a finished access until the pipeline advances.
module dmem_request_ctrl #(
    parameter int WAIT_LIMIT = 1024,
    parameter int CNT_W      = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             flush,
    input  logic             memren,
    input  logic             memwen,
    input  logic [31:0]      memaddr,
    input  logic [31:0]      memstore,
    input  logic             dhit_in,
    input  logic [31:0]      dmemload_in,
    output logic             dmemREN,
    output logic             dmemWEN,
    output logic [31:0]      dmemaddr,
    output logic [31:0]      dmemstore,
    output logic             dhit,
    output logic [31:0]      load,
    output logic             mem_stall,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             wd_err,
    output logic [1:0]       fsm_state
);

    localparam int WC_W = $clog2(WAIT_LIMIT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state, next_state;
    logic            req_raw;
    logic            req;
    logic [WC_W-1:0] wait_cnt;

    // Handshake: a request is offered (REN/WEN) every cycle req is high and is
    // accepted on the cycle dhit_in is also high; the request is held stable until then.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= S_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        req_raw    = 1'b0;
        next_state = state;
        case (state)
            S_IDLE: begin
                if (!flush) begin
                    req_raw = memren | memwen;
                    if (req_raw && dhit_in) next_state = ihit ? S_IDLE : S_DONE;
                    else if (req_raw)       next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                // An issued access always completes; flush is ignored here.
                req_raw = memren | memwen;
                if (req_raw && dhit_in) next_state = ihit ? S_IDLE : S_DONE;
            end
            S_DONE: begin
                if (ihit || flush) next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Gating with nRST drops the dcache request asynchronously during reset.
    assign req       = nRST & req_raw;
    assign dmemWEN   = req & memwen;
    assign dmemREN   = req & memren & ~memwen;
    assign dmemaddr  = memaddr;
    assign dmemstore = memstore;
    assign mem_stall = req & ~dhit_in;
    assign fsm_state = state;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            dhit <= 1'b0;
            load <= 32'd0;
        end else begin
            dhit <= req & dhit_in;
            if (dmemREN && dhit_in) load <= dmemload_in;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cnt <= '0;
        end else if (mem_stall && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wait_cnt <= '0;
            wd_err   <= 1'b0;
        end else begin
            if (state == S_WAIT && next_state == S_WAIT) begin
                if (wait_cnt != WC_W'(WAIT_LIMIT)) wait_cnt <= wait_cnt + WC_W'(1);
            end else begin
                wait_cnt <= '0;
            end
            if (wait_cnt == WC_W'(WAIT_LIMIT)) wd_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dmem_request_ctrl.sv
// Bench for dmem_request_ctrl: directed vector table, hand sequences for watchdog and
// mid-request reset, then randomized traffic against a transaction-level model.
module tb_dmem_request_ctrl;

    localparam int WL = 8;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        ihit = 1'b0, flush = 1'b0, memren = 1'b0, memwen = 1'b0, dhit_in = 1'b0;
    logic [31:0] memaddr = '0, memstore = '0, dmemload_in = '0;
    logic        dmemREN, dmemWEN, dhit, mem_stall, wd_err;
    logic [31:0] dmemaddr, dmemstore, load, stall_cnt;
    logic [1:0]  fsm_state;

    dmem_request_ctrl #(.WAIT_LIMIT(WL), .CNT_W(32)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .flush(flush),
        .memren(memren), .memwen(memwen), .memaddr(memaddr), .memstore(memstore),
        .dhit_in(dhit_in), .dmemload_in(dmemload_in),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
        .dhit(dhit), .load(load), .mem_stall(mem_stall), .stall_cnt(stall_cnt),
        .wd_err(wd_err), .fsm_state(fsm_state)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        ren, wen, fl, ih, dh;
        logic [31:0] addr, sdata, rdata;
        logic        e_ren, e_wen, e_stall, e_dhit;
        logic [31:0] e_load, e_scnt;
        logic [1:0]  e_st;
    } vec_t;

    vec_t vecs[15];

    function automatic vec_t mk(logic ren, logic wen, logic fl, logic ih, logic dh,
                                logic [31:0] addr, logic [31:0] sdata, logic [31:0] rdata,
                                logic e_ren, logic e_wen, logic e_stall, logic e_dhit,
                                logic [31:0] e_load, logic [31:0] e_scnt, logic [1:0] e_st);
        vec_t v;
        v.ren = ren; v.wen = wen; v.fl = fl; v.ih = ih; v.dh = dh;
        v.addr = addr; v.sdata = sdata; v.rdata = rdata;
        v.e_ren = e_ren; v.e_wen = e_wen; v.e_stall = e_stall; v.e_dhit = e_dhit;
        v.e_load = e_load; v.e_scnt = e_scnt; v.e_st = e_st;
        return v;
    endfunction

    // Reference model state: an access is either outstanding, finished-awaiting-ihit, or neither.
    logic        m_busy, m_done, m_wd, m_dhit;
    int          m_waits;
    logic [31:0] m_load, m_scnt;

    initial begin
        logic m_req, e_ren, e_wen, e_stall, hit;

        // ren wen fl ih dh  addr     sdata         rdata         |ren wen stl dhit load          scnt st
        vecs[0]  = mk(1,0,0,1,1, 32'h100, 32'h0,        32'hDEADBEEF, 1,0,0,1, 32'hDEADBEEF, 0, 0);
        vecs[1]  = mk(0,0,0,0,0, 32'h104, 32'h0,        32'h0BADF00D, 0,0,0,0, 32'hDEADBEEF, 0, 0);
        vecs[2]  = mk(0,1,0,0,0, 32'h200, 32'h12345678, 32'h0,        0,1,1,0, 32'hDEADBEEF, 1, 1);
        vecs[3]  = mk(0,1,0,0,0, 32'h200, 32'h12345678, 32'h0,        0,1,1,0, 32'hDEADBEEF, 2, 1);
        vecs[4]  = mk(0,1,0,0,0, 32'h200, 32'h12345678, 32'h0,        0,1,1,0, 32'hDEADBEEF, 3, 1);
        vecs[5]  = mk(0,1,0,0,1, 32'h200, 32'h12345678, 32'hAAAA5555, 0,1,0,1, 32'hDEADBEEF, 3, 2);
        vecs[6]  = mk(0,1,0,0,1, 32'h200, 32'h12345678, 32'hAAAA5555, 0,0,0,0, 32'hDEADBEEF, 3, 2);
        vecs[7]  = mk(0,1,0,1,0, 32'h200, 32'h12345678, 32'h0,        0,0,0,0, 32'hDEADBEEF, 3, 0);
        vecs[8]  = mk(1,1,0,1,1, 32'h280, 32'h87654321, 32'hCAFEF00D, 0,1,0,1, 32'hDEADBEEF, 3, 0);
        vecs[9]  = mk(1,0,0,0,0, 32'h300, 32'h0,        32'h0,        1,0,1,0, 32'hDEADBEEF, 4, 1);
        vecs[10] = mk(1,0,1,0,0, 32'h300, 32'h0,        32'h0,        1,0,1,0, 32'hDEADBEEF, 5, 1);
        vecs[11] = mk(1,0,1,0,1, 32'h300, 32'h0,        32'h11112222, 1,0,0,1, 32'h11112222, 5, 2);
        vecs[12] = mk(1,0,1,0,1, 32'h300, 32'h0,        32'h99998888, 0,0,0,0, 32'h11112222, 5, 0);
        vecs[13] = mk(1,0,0,1,1, 32'h304, 32'h0,        32'h33334444, 1,0,0,1, 32'h33334444, 5, 0);
        vecs[14] = mk(1,0,1,0,1, 32'h308, 32'h0,        32'h55556666, 0,0,0,0, 32'h33334444, 5, 0);

        // Reset state
        #1;
        chk("rst_ren", dmemREN, 0);
        chk("rst_wen", dmemWEN, 0);
        chk("rst_dhit", dhit, 0);
        chk("rst_load", load, 0);
        chk("rst_scnt", stall_cnt, 0);
        chk("rst_wd", wd_err, 0);
        @(negedge CLK); @(negedge CLK);
        nRST = 1'b1;

        // Directed table
        for (int i = 0; i < 15; i++) begin
            @(negedge CLK);
            memren = vecs[i].ren; memwen = vecs[i].wen; flush = vecs[i].fl;
            ihit = vecs[i].ih; dhit_in = vecs[i].dh; memaddr = vecs[i].addr;
            memstore = vecs[i].sdata; dmemload_in = vecs[i].rdata;
            #1;
            chk($sformatf("v%0d_ren", i), dmemREN, vecs[i].e_ren);
            chk($sformatf("v%0d_wen", i), dmemWEN, vecs[i].e_wen);
            chk($sformatf("v%0d_stall", i), mem_stall, vecs[i].e_stall);
            chk($sformatf("v%0d_addr", i), dmemaddr, vecs[i].addr);
            chk($sformatf("v%0d_sdata", i), dmemstore, vecs[i].sdata);
            @(posedge CLK); #1;
            chk($sformatf("v%0d_dhit", i), dhit, vecs[i].e_dhit);
            chk($sformatf("v%0d_load", i), load, vecs[i].e_load);
            chk($sformatf("v%0d_scnt", i), stall_cnt, vecs[i].e_scnt);
            chk($sformatf("v%0d_state", i), fsm_state, vecs[i].e_st);
        end

        // Watchdog: withhold dhit_in well past WL cycles
        @(negedge CLK);
        memren = 1; memwen = 0; flush = 0; ihit = 0; dhit_in = 0; memaddr = 32'h400;
        repeat (7) @(posedge CLK);
        #1 chk("wd_early", wd_err, 0);
        repeat (6) @(posedge CLK);
        #1 chk("wd_set", wd_err, 1);
        @(negedge CLK);
        dhit_in = 1; ihit = 1;
        @(negedge CLK);
        memren = 0; dhit_in = 0; ihit = 0;
        repeat (3) @(posedge CLK);
        #1 chk("wd_sticky", wd_err, 1);
        chk("wd_state", fsm_state, 0);

        // Reset in the middle of an outstanding load
        @(negedge CLK);
        memren = 1; dhit_in = 0; dmemload_in = 32'h77777777;
        @(posedge CLK);
        @(negedge CLK);
        chk("pre_rst_stall", mem_stall, 1);
        nRST = 1'b0;
        #1;
        chk("mrst_ren", dmemREN, 0);
        chk("mrst_stall", mem_stall, 0);
        chk("mrst_load", load, 0);
        chk("mrst_dhit", dhit, 0);
        chk("mrst_scnt", stall_cnt, 0);
        chk("mrst_wd", wd_err, 0);
        chk("mrst_state", fsm_state, 0);
        memren = 0;
        @(negedge CLK);
        nRST = 1'b1;

        // Randomized traffic against the model
        m_busy = 0; m_done = 0; m_wd = 0; m_dhit = 0; m_waits = 0; m_load = 0; m_scnt = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge CLK);
            if (!m_busy) begin
                memren   = 1'($urandom_range(0, 1));
                memwen   = ($urandom_range(0, 3) == 0);
                memaddr  = $urandom;
                memstore = $urandom;
            end
            flush       = ($urandom_range(0, 7) == 0);
            ihit        = 1'($urandom_range(0, 1));
            dhit_in     = ($urandom_range(0, 9) < 4);
            dmemload_in = $urandom;
            #1;
            m_req   = ~m_done & (memren | memwen) & (m_busy | ~flush);
            e_wen   = m_req & memwen;
            e_ren   = m_req & memren & ~memwen;
            e_stall = m_req & ~dhit_in;
            hit     = m_req & dhit_in;
            chk("rnd_ren", dmemREN, e_ren);
            chk("rnd_wen", dmemWEN, e_wen);
            chk("rnd_stall", mem_stall, e_stall);
            chk("rnd_addr", dmemaddr, memaddr);

            if (m_waits >= WL) m_wd = 1;
            if (e_stall && m_scnt != 32'hFFFFFFFF) m_scnt = m_scnt + 1;
            m_dhit = hit;
            if (e_ren && dhit_in) m_load = dmemload_in;
            if (hit) begin
                m_busy = 0; m_waits = 0; m_done = ~ihit;
            end else if (m_busy) begin
                m_waits++;
            end else if (m_req) begin
                m_busy = 1;
            end else if (m_done && (ihit || flush)) begin
                m_done = 0;
            end

            @(posedge CLK); #1;
            chk("rnd_dhit", dhit, m_dhit);
            chk("rnd_load", load, m_load);
            chk("rnd_scnt", stall_cnt, m_scnt);
            chk("rnd_wd", wd_err, m_wd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
